// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_arbiter_2m                                                   |
// | Purpose  : Two-master / one-slave Wishbone arbiter. Master 0 is the        |
// |            instruction fetch unit and master 1 is the load/store unit.     |
// |            A grant is held for a master's whole CYC-framed transaction,    |
// |            ties alternate between the masters, and a watchdog aborts       |
// |            strobes the slave never answers.                                |
// | Ports    : clk, rst (sync, active-low)                                     |
// |            m0_*/m1_* : master-side cyc/stb/we/adr/dat_o in, dat_i/ack out  |
// |            s_*       : slave-side cyc/stb/we/adr/dat_o out, dat_i/ack in   |
// |            grant     : one-hot owner (01 = m0, 10 = m1, 00 = none)         |
// |            bus_err   : one-cycle pulse on a watchdog abort                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_arbiter_2m #(
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_o,
  output logic [31:0] m0_dat_i,
  output logic        m0_ack,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_o,
  output logic [31:0] m1_dat_i,
  output logic        m1_ack,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  output logic [1:0]  grant,
  output logic        bus_err
);

  // Watchdog counter wide enough to hold TIMEOUT (at least one bit).
  localparam int             WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [1:0]        grant_q, grant_d;

  logic              sel0, sel1;
  logic              stb_sel;
  logic              wd_hit;
  logic              abort;

  assign sel0    = (state_q == GNT0);
  assign sel1    = (state_q == GNT1);
  assign stb_sel = (sel0 & m0_stb) | (sel1 & m1_stb);

  // The hit is decided without looking at s_ack so that a slave whose ACK is
  // combinational on STB cannot form a loop through the forced-low strobe.
  assign wd_hit = (TIMEOUT != 0) && stb_sel && (wd_q == WD_MAX);
  // A real ACK arriving in the hit cycle wins over the forced abort.
  assign abort  = wd_hit & ~s_ack;

  // Slave-side mux: straight copy of the owner, all zero while idle.
  always_comb begin
    s_cyc   = 1'b0;
    s_we    = 1'b0;
    s_adr   = 32'h0;
    s_dat_o = 32'h0;
    if (sel0) begin
      s_cyc   = m0_cyc;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_dat_o = m0_dat_o;
    end else if (sel1) begin
      s_cyc   = m1_cyc;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_dat_o = m1_dat_o;
    end
  end

  assign s_stb = stb_sel & ~wd_hit;

  // Master-side return path: only the owner ever sees ACK or data.
  assign m0_ack   = sel0 & (s_ack | abort);
  assign m1_ack   = sel1 & (s_ack | abort);
  assign m0_dat_i = sel0 ? (abort ? TIMEOUT_DATA : s_dat_i) : 32'h0;
  assign m1_dat_i = sel1 ? (abort ? TIMEOUT_DATA : s_dat_i) : 32'h0;
  assign bus_err  = abort;
  assign grant    = grant_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        // On a tie, grant whichever master was not served last.
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = GNT0;
        end else if (m1_cyc) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc) begin
          last_d  = 1'b0;
          state_d = m1_cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          last_d  = 1'b1;
          state_d = m0_cyc ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d = (state_d == GNT0) ? 2'b01 :
              (state_d == GNT1) ? 2'b10 : 2'b00;

    // Watchdog counts consecutive unanswered strobe cycles of one owner.
    if ((state_d != state_q) || !stb_sel || s_ack || wd_hit) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      grant_q <= grant_d;
    end
  end

endmodule
`default_nettype wire
